// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - CPU-side controller for a 2-way set-associative cache array
// Read misses refill the 8-word block into the LRU way; writes go through to memory with no allocate.
module cache_refill_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int INDEX_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              c_sel0,
   output logic              c_sel1,
   output logic              c_we,
   output logic [ADDR_W-1:0] c_addr,
   output logic [DATA_W-1:0] c_di0,
   output logic [DATA_W-1:0] c_di1,
   input  logic              HIT0,
   input  logic              HIT1,
   input  logic [DATA_W-1:0] dout0,
   input  logic [DATA_W-1:0] dout1,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int NSETS  = 1 << INDEX_W;
   localparam int TAG_LO = INDEX_W + 5;

   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WMEM, RESP} state_t;
   state_t state, state_nxt;

   logic [ADDR_W-1:0]  req_addr;
   logic               req_we;
   logic [DATA_W-1:0]  req_wdata;
   logic               victim;
   logic [2:0]         cnt;
   logic [NSETS-1:0]   lru;
   logic [INDEX_W-1:0] idx;
   logic [2:0]         word;
   logic [ADDR_W-1:0]  fill_addr;
   logic               hit;

   assign idx       = req_addr[TAG_LO-1:5];
   assign word      = req_addr[4:2];
   assign fill_addr = {req_addr[ADDR_W-1:5], cnt, 2'b00};
   assign hit       = HIT0 | HIT1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cpu_done  = 1'b0;
      c_we      = 1'b0;
      c_sel0    = 1'b0;
      c_sel1    = 1'b0;
      c_addr    = req_addr;
      c_di0     = '0;
      c_di1     = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            if (cpu_req) state_nxt = LOOKUP;
         end
         LOOKUP: begin
            if (req_we) begin
               // Way 0 wins if both tags match
               if (hit) begin
                  c_we   = 1'b1;
                  c_sel0 = HIT0;
                  c_sel1 = !HIT0;
                  if (HIT0) c_di0 = req_wdata;
                  else      c_di1 = req_wdata;
               end
               state_nxt = WMEM;
            end else begin
               state_nxt = hit ? RESP : FILL;
            end
         end
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = fill_addr;
            c_addr   = fill_addr;
            if (mem_rvalid) begin
               c_we   = 1'b1;
               c_sel0 = !victim;
               c_sel1 = victim;
               if (victim) c_di1 = mem_rdata;
               else        c_di0 = mem_rdata;
               if (cnt == 3'd7) state_nxt = RESP;
            end
         end
         WMEM: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = req_addr;
            mem_wdata = req_wdata;
            if (mem_rvalid) state_nxt = RESP;
         end
         RESP: begin
            cpu_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_addr  <= '0;
         req_we    <= 1'b0;
         req_wdata <= '0;
         victim    <= 1'b0;
         cnt       <= 3'd0;
         lru       <= '0;
         cpu_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  req_addr  <= cpu_addr;
                  req_we    <= cpu_we;
                  req_wdata <= cpu_wdata;
               end
            end
            LOOKUP: begin
               // LRU bit names the victim, so a hit on way k leaves ~k
               if (hit) begin
                  lru[idx] <= HIT0;
                  if (!req_we) cpu_rdata <= HIT0 ? dout0 : dout1;
               end else if (!req_we) begin
                  victim <= lru[idx];
                  cnt    <= 3'd0;
               end
            end
            FILL: begin
               if (mem_rvalid) begin
                  if (cnt == word) cpu_rdata <= mem_rdata;
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7) lru[idx] <= ~victim;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - directed and randomized checks of cache_refill_ctrl against a cache-level model
module tb_cache_refill_ctrl;
   localparam int LAT = 2;

   logic        clk;
   logic        rst_n;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        cpu_done;
   logic [31:0] cpu_rdata;
   logic        c_sel0, c_sel1, c_we;
   logic [31:0] c_addr, c_di0, c_di1;
   logic        HIT0, HIT1;
   logic [31:0] dout0, dout1;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;

   cache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .INDEX_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .c_sel0(c_sel0), .c_sel1(c_sel1), .c_we(c_we), .c_addr(c_addr),
      .c_di0(c_di0), .c_di1(c_di1), .HIT0(HIT0), .HIT1(HIT1),
      .dout0(dout0), .dout1(dout1),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cache array: combinational read, write on the rising edge
   logic [31:0] arr_data  [2][32][8];
   logic [21:0] arr_tag   [2][32];
   logic        arr_valid [2][32];

   always_comb begin
      HIT0  = arr_valid[0][c_addr[9:5]] && (arr_tag[0][c_addr[9:5]] == c_addr[31:10]);
      HIT1  = arr_valid[1][c_addr[9:5]] && (arr_tag[1][c_addr[9:5]] == c_addr[31:10]);
      dout0 = arr_data[0][c_addr[9:5]][c_addr[4:2]];
      dout1 = arr_data[1][c_addr[9:5]][c_addr[4:2]];
   end

   logic        pw_we = 1'b0;
   logic        pw_s0 = 1'b0, pw_s1 = 1'b0;
   logic [31:0] pw_addr = 32'd0, pw_d0 = 32'd0, pw_d1 = 32'd0;
   int          n_we0 = 0, n_we1 = 0, n_done = 0;

   always @(negedge clk) begin
      #4;
      pw_we   = c_we;
      pw_s0   = c_sel0;
      pw_s1   = c_sel1;
      pw_addr = c_addr;
      pw_d0   = c_di0;
      pw_d1   = c_di1;
      if (c_we && c_sel0) n_we0++;
      if (c_we && c_sel1) n_we1++;
      if (cpu_done) n_done++;
   end

   always @(posedge clk) begin
      if (rst_n && pw_we) begin
         if (pw_s0) begin
            arr_data[0][pw_addr[9:5]][pw_addr[4:2]] = pw_d0;
            arr_tag[0][pw_addr[9:5]]   = pw_addr[31:10];
            arr_valid[0][pw_addr[9:5]] = 1'b1;
         end
         if (pw_s1) begin
            arr_data[1][pw_addr[9:5]][pw_addr[4:2]] = pw_d1;
            arr_tag[1][pw_addr[9:5]]   = pw_addr[31:10];
            arr_valid[1][pw_addr[9:5]] = 1'b1;
         end
      end
      pw_we = 1'b0;
   end

   // Main memory: default contents addr+1, ack LAT cycles after request, tolerates dropped requests
   logic [31:0] env_mem [logic [31:0]];
   logic [31:0] rd_log [$];
   logic [63:0] wr_log [$];
   int          mwait = 0;

   function automatic logic [31:0] env_rd(input logic [31:0] a);
      return env_mem.exists(a) ? env_mem[a] : a + 32'd1;
   endfunction

   always @(negedge clk) begin
      if (mem_rvalid) begin
         mem_rvalid = 1'b0;
         mwait      = 0;
      end
      if (mem_req) begin
         mwait++;
         if (mwait == LAT) begin
            mem_rvalid = 1'b1;
            if (mem_we) begin
               env_mem[mem_addr] = mem_wdata;
               wr_log.push_back({mem_addr, mem_wdata});
            end else begin
               mem_rdata = env_rd(mem_addr);
               rd_log.push_back(mem_addr);
            end
         end
      end else begin
         mwait = 0;
      end
   end

   // Reference model: cache-level view of tags, LRU and memory contents
   logic        ref_valid [2][32];
   logic [21:0] ref_tag   [2][32];
   logic        ref_lru   [32];
   logic [31:0] ref_mem   [logic [31:0]];

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : a + 32'd1;
   endfunction

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      logic [4:0]  idx;
      logic [21:0] tag;
      logic        h0, h1, way;
      logic [31:0] exp_data;
      int exp_lat, lat, exp_rd, exp_wr, exp_we0, exp_we1;
      int we0_s, we1_s, rd_s, wr_s;
      idx = addr[9:5];
      tag = addr[31:10];
      h0  = ref_valid[0][idx] && (ref_tag[0][idx] == tag);
      h1  = ref_valid[1][idx] && (ref_tag[1][idx] == tag);
      way = h0 ? 1'b0 : 1'b1;
      exp_rd = 0; exp_wr = 0; exp_we0 = 0; exp_we1 = 0;
      if (we) begin
         exp_lat = 2 + LAT;
         exp_wr  = 1;
         ref_mem[addr] = wd;
         if (h0 || h1) begin
            if (way) exp_we1 = 1;
            else     exp_we0 = 1;
            ref_lru[idx] = ~way;
         end
      end else if (h0 || h1) begin
         exp_lat = 2;
         ref_lru[idx] = ~way;
      end else begin
         exp_lat = 2 + 8 * LAT;
         exp_rd  = 8;
         way     = ref_lru[idx];
         if (way) exp_we1 = 8;
         else     exp_we0 = 8;
         ref_valid[way][idx] = 1'b1;
         ref_tag[way][idx]   = tag;
         ref_lru[idx]        = ~way;
      end
      exp_data = ref_rd(addr);
      we0_s = n_we0; we1_s = n_we1; rd_s = rd_log.size(); wr_s = wr_log.size();

      @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      lat = 999;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (cpu_done) begin
            lat = n;
            break;
         end
      end
      cpu_req = 1'b0;
      check("latency", 64'(lat), 64'(exp_lat));
      if (!we) check("rdata", 64'(cpu_rdata), 64'(exp_data));
      @(posedge clk);
      #1;
      check("done_pulse", 64'(cpu_done), 64'd0);
      if (!we) check("rdata_hold", 64'(cpu_rdata), 64'(exp_data));
      check("mem_reads", 64'(rd_log.size() - rd_s), 64'(exp_rd));
      if (exp_rd == 8 && rd_log.size() - rd_s == 8)
         for (int i = 0; i < 8; i++)
            check("fill_addr", 64'(rd_log[rd_s + i]), 64'({addr[31:5], 5'd0} + 32'(4 * i)));
      check("mem_writes", 64'(wr_log.size() - wr_s), 64'(exp_wr));
      if (we && wr_log.size() > wr_s) check("mem_wr_data", wr_log[wr_s], {addr, wd});
      check("arr_we0", 64'(n_we0 - we0_s), 64'(exp_we0));
      check("arr_we1", 64'(n_we1 - we1_s), 64'(exp_we1));
      check("lru", 64'(dut.lru[idx]), 64'(ref_lru[idx]));
   endtask

   initial begin
      int rd_s, d_s;
      logic v;
      rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      for (int w = 0; w < 2; w++)
         for (int s = 0; s < 32; s++) begin
            arr_valid[w][s] = 1'b0; arr_tag[w][s] = 22'd0;
            ref_valid[w][s] = 1'b0; ref_tag[w][s] = 22'd0;
            for (int k = 0; k < 8; k++) arr_data[w][s][k] = 32'd0;
         end
      for (int s = 0; s < 32; s++) ref_lru[s] = 1'b0;
      #2;
      check("rst_done", 64'(cpu_done), 64'd0);
      check("rst_rdata", 64'(cpu_rdata), 64'd0);
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_c_we", 64'(c_we), 64'd0);
      check("rst_c_addr", 64'(c_addr), 64'd0);
      check("rst_lru", 64'(dut.lru), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      do_op(1'b0, 32'd256, 32'd0);
      do_op(1'b0, 32'd260, 32'd0);
      do_op(1'b0, 32'd1280, 32'd0);
      do_op(1'b0, 32'd260, 32'd0);
      do_op(1'b0, 32'd2304, 32'd0);
      do_op(1'b0, 32'd1280, 32'd0);
      do_op(1'b1, 32'd288, 32'd20);
      do_op(1'b0, 32'd288, 32'd0);
      do_op(1'b1, 32'd292, 32'd7);
      do_op(1'b0, 32'd292, 32'd0);

      // Abort a fill of index 9 (tag 5) after three words
      rd_s = rd_log.size();
      d_s  = n_done;
      v    = ref_lru[9];
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd5408;
      for (int n = 0; n < 100 && (rd_log.size() - rd_s) < 3; n++) @(posedge clk);
      #2;
      check("fill_busy", 64'(mem_req), 64'd1);
      check("fill_word3", 64'(mem_addr), 64'd5420);
      rst_n = 1'b0;
      #1;
      check("arst_mem_req", 64'(mem_req), 64'd0);
      check("arst_c_we", 64'(c_we), 64'd0);
      check("arst_sel", 64'({c_sel0, c_sel1}), 64'd0);
      check("arst_done", 64'(cpu_done), 64'd0);
      check("arst_mem_addr", 64'(mem_addr), 64'd0);
      check("arst_lru", 64'(dut.lru), 64'd0);
      ref_valid[v][9] = 1'b1;
      ref_tag[v][9]   = 22'd5;
      for (int s = 0; s < 32; s++) ref_lru[s] = 1'b0;
      cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_no_done", 64'(n_done - d_s), 64'd0);
      do_op(1'b0, 32'd1312, 32'd0);

      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         a = ({30'd0, 2'($urandom_range(0, 3))} << 10) | (32'(8 + $urandom_range(0, 3)) << 5)
             | (32'($urandom_range(0, 7)) << 2);
         do_op(($urandom_range(0, 9) < 3), a, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
